// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory read port, hazard/redirect controls
// and the IF/ID pipeline register outputs.
interface instruction_fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 8
);
  logic [PC_WIDTH-1:0]    pc_out;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic                   stall;
  logic                   flush;
  logic                   jump_valid;
  logic [PC_WIDTH-1:0]    jump_target;
  logic                   if_id_valid;
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic [PC_WIDTH-1:0]    if_id_pc;
  logic                   halted;

  // master: the fetch unit; slave: memory, hazard unit and decode stage
  modport master (
    output pc_out, if_id_valid, if_id_instr, if_id_pc, halted,
    input  instr_in, stall, flush, jump_valid, jump_target
  );

  modport slave (
    input  pc_out, if_id_valid, if_id_instr, if_id_pc, halted,
    output instr_in, stall, flush, jump_valid, jump_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory and fills IF/ID.
// Optional macro FETCH_WRAP_EN: PC wraps at MEM_DEPTH instead of halting.
module instruction_fetch_unit #(
  parameter int                       PC_WIDTH    = 8,
  parameter int                       INSTR_WIDTH = 8,
  parameter int                       MEM_DEPTH   = 6,
  parameter logic [PC_WIDTH-1:0]      RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]   NOP_CODE    = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  instruction_fetch_unit_if.master    bus
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [PC_WIDTH:0] DEPTH = (PC_WIDTH+1)'(MEM_DEPTH);

  state_t                 state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic                   valid_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    ifpc_q;

  logic                   in_range;
  logic                   jump_in_range;
  logic [PC_WIDTH-1:0]    pc_inc_d;
  logic [PC_WIDTH-1:0]    jump_pc_d;
  logic [PC_WIDTH:0]      jump_mod;

  // Range checks use the pre-increment PC so 'hFF cannot wrap silently into memory
  always_comb begin
    jump_mod = '0;
`ifdef FETCH_WRAP_EN
    in_range      = 1'b1;
    jump_in_range = 1'b1;
    jump_mod      = {1'b0, bus.jump_target} % DEPTH;
    jump_pc_d     = jump_mod[PC_WIDTH-1:0];
    pc_inc_d      = ({1'b0, pc_q} >= DEPTH - 1'b1) ? '0 : pc_q + 1'b1;
`else
    in_range      = ({1'b0, pc_q} < DEPTH);
    jump_in_range = ({1'b0, bus.jump_target} < DEPTH);
    jump_pc_d     = bus.jump_target;
    pc_inc_d      = pc_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_CODE;
      ifpc_q  <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.jump_valid) begin
            pc_q    <= jump_pc_d;
            valid_q <= 1'b0;
            instr_q <= NOP_CODE;
            if (!jump_in_range) state_q <= HALT;
          end else if (bus.flush) begin
            valid_q <= 1'b0;
            instr_q <= NOP_CODE;
            if (!in_range)       state_q <= HALT;
            else if (!bus.stall) pc_q    <= pc_inc_d;
          end else if (bus.stall) begin
            pc_q <= pc_q;
          end else if (in_range) begin
            instr_q <= bus.instr_in;
            ifpc_q  <= pc_q;
            valid_q <= 1'b1;
            pc_q    <= pc_inc_d;
          end else begin
            // Ran off the end of the program: drain IF/ID and stop
            valid_q <= 1'b0;
            instr_q <= NOP_CODE;
            state_q <= HALT;
          end
        end
        HALT: begin
          if (bus.jump_valid && jump_in_range) begin
            pc_q    <= jump_pc_d;
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.if_id_valid = valid_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ifpc_q;
`ifdef FETCH_WRAP_EN
  assign bus.halted      = 1'b0;
`else
  assign bus.halted      = (state_q == HALT);
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Table-driven bench for instruction_fetch_unit: each row gives the inputs
// before a rising edge and the outputs expected just after it.
module tb_instruction_fetch_unit;

  logic clk;
  logic reset;

  instruction_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(8)) bus();

  instruction_fetch_unit #(
    .PC_WIDTH(8), .INSTR_WIDTH(8), .MEM_DEPTH(6),
    .RESET_PC(8'h00), .NOP_CODE(8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:5];
  initial begin
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66;
  end

  always_comb begin
    if (bus.pc_out < 8'd6) bus.instr_in = mem[bus.pc_out[2:0]];
    else                   bus.instr_in = 8'hEE;
  end

  typedef struct {
    logic       rst_n;
    logic       stall;
    logic       flush;
    logic       jv;
    logic [7:0] jt;
    logic [7:0] pc;
    logic       v;
    logic [7:0] ins;
    logic [7:0] ipc;
    logic       h;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(logic r, logic s, logic f, logic j, logic [7:0] t,
                              logic [7:0] pc, logic v, logic [7:0] ins,
                              logic [7:0] ipc, logic h);
    vec_t e;
    e.rst_n = r; e.stall = s; e.flush = f; e.jv = j; e.jt = t;
    e.pc = pc; e.v = v; e.ins = ins; e.ipc = ipc; e.h = h;
    tbl.push_back(e);
  endfunction

  task automatic chk(string nm, int row, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s row=%0d got=%0h want=%0h", nm, row, got, want);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.jump_valid = 1'b0; bus.jump_target = 8'h00;

`ifdef FETCH_WRAP_EN
    //   rst  st fl jv tgt    pc    v  instr  ifpc  h
    add(1'b0, 0, 0, 0, 8'd0,  8'd0, 0, 8'h00, 8'd0, 0);
    for (int k = 1; k <= 14; k++)
      add(1'b1, 0, 0, 0, 8'd0, 8'(k % 6), 1, mem[(k-1) % 6], 8'((k-1) % 6), 0);
    add(1'b1, 0, 0, 1, 8'd8,  8'd2, 0, 8'h00, 8'd1, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd3, 1, 8'h33, 8'd2, 0);
`else
    //   rst  st fl jv tgt    pc    v  instr  ifpc  h
    add(1'b0, 0, 0, 0, 8'd0,  8'd0, 0, 8'h00, 8'd0, 0);  // reset
    add(1'b1, 0, 0, 0, 8'd0,  8'd1, 1, 8'h11, 8'd0, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd2, 1, 8'h22, 8'd1, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd3, 1, 8'h33, 8'd2, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd4, 1, 8'h44, 8'd3, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd5, 1, 8'h55, 8'd4, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd6, 1, 8'h66, 8'd5, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd6, 0, 8'h00, 8'd5, 1);  // end of program
    add(1'b1, 1, 1, 0, 8'd0,  8'd6, 0, 8'h00, 8'd5, 1);  // stall/flush ignored in HALT
    add(1'b1, 0, 0, 1, 8'd9,  8'd6, 0, 8'h00, 8'd5, 1);  // out-of-range jump stays halted
    add(1'b1, 0, 0, 1, 8'd1,  8'd1, 0, 8'h00, 8'd5, 0);  // leave HALT
    add(1'b1, 0, 0, 0, 8'd0,  8'd2, 1, 8'h22, 8'd1, 0);
    add(1'b1, 1, 0, 0, 8'd0,  8'd2, 1, 8'h22, 8'd1, 0);  // stall x3 at pc 2
    add(1'b1, 1, 0, 0, 8'd0,  8'd2, 1, 8'h22, 8'd1, 0);
    add(1'b1, 1, 0, 0, 8'd0,  8'd2, 1, 8'h22, 8'd1, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd3, 1, 8'h33, 8'd2, 0);
    add(1'b1, 0, 1, 0, 8'd0,  8'd4, 0, 8'h00, 8'd2, 0);  // flush at pc 3
    add(1'b1, 0, 0, 0, 8'd0,  8'd5, 1, 8'h55, 8'd4, 0);
    add(1'b1, 0, 0, 1, 8'd1,  8'd1, 0, 8'h00, 8'd4, 0);
    add(1'b1, 1, 0, 1, 8'd4,  8'd4, 0, 8'h00, 8'd4, 0);  // jump beats stall
    add(1'b1, 0, 0, 0, 8'd0,  8'd5, 1, 8'h55, 8'd4, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd6, 1, 8'h66, 8'd5, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd6, 0, 8'h00, 8'd5, 1);
    add(1'b1, 0, 0, 1, 8'd2,  8'd2, 0, 8'h00, 8'd5, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd3, 1, 8'h33, 8'd2, 0);
    add(1'b0, 0, 0, 1, 8'd5,  8'd0, 0, 8'h00, 8'd0, 0);  // reset overrides jump
    add(1'b1, 0, 0, 0, 8'd0,  8'd1, 1, 8'h11, 8'd0, 0);
    add(1'b1, 0, 0, 1, 8'd8,  8'd8, 0, 8'h00, 8'd0, 1);  // out-of-range jump from RUN
    add(1'b1, 1, 0, 0, 8'd0,  8'd8, 0, 8'h00, 8'd0, 1);
    add(1'b1, 0, 0, 1, 8'd3,  8'd3, 0, 8'h00, 8'd0, 0);
    add(1'b1, 1, 1, 0, 8'd0,  8'd3, 0, 8'h00, 8'd0, 0);  // flush+stall holds pc
    add(1'b1, 1, 0, 0, 8'd0,  8'd3, 0, 8'h00, 8'd0, 0);
    add(1'b1, 0, 0, 0, 8'd0,  8'd4, 1, 8'h44, 8'd3, 0);
`endif

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      reset           = tbl[i].rst_n;
      bus.stall       = tbl[i].stall;
      bus.flush       = tbl[i].flush;
      bus.jump_valid  = tbl[i].jv;
      bus.jump_target = tbl[i].jt;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      begin
        vec_t e;
        e = sb.pop_front();
        chk("pc_out",      i, bus.pc_out,              e.pc);
        chk("if_id_valid", i, {7'd0, bus.if_id_valid}, {7'd0, e.v});
        chk("if_id_instr", i, bus.if_id_instr,         e.ins);
        chk("if_id_pc",    i, bus.if_id_pc,            e.ipc);
        chk("halted",      i, {7'd0, bus.halted},      {7'd0, e.h});
      end
    end

    // Sustained stall: hold for many cycles without drift
    bus.jump_valid = 1'b0; bus.flush = 1'b0; bus.stall = 1'b1;
    repeat (20) @(posedge clk);
    #1;
`ifdef FETCH_WRAP_EN
    chk("long_stall_pc",    999, bus.pc_out,      8'd3);
    chk("long_stall_instr", 999, bus.if_id_instr, 8'h33);
`else
    chk("long_stall_pc",    999, bus.pc_out,      8'd4);
    chk("long_stall_instr", 999, bus.if_id_instr, 8'h44);
`endif
    bus.stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
